// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem request at a time, one instruction
// presented per decoder handshake, jump/branch redirects applied on the consume cycle.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction memory
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  // decoder side
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [5:0]        opcode_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [31:0]       issue_count_o
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_RESET   = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic                capture_c;
  logic                consume_c;
  logic [ADDR_W-1:0]   next_pc_c;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]   pc_plus4_q, pc_plus4_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (imem_gnt_i)    state_d = ST_WAIT;
      ST_WAIT:  if (imem_rvalid_i) state_d = ST_ISSUE;
      ST_ISSUE: if (!stall_i)      state_d = ST_FETCH;
      default:  state_d = ST_RST;
    endcase
  end

  // Output decode; req/valid are registered from the next state so they track state_q
  always_comb begin
    req_d     = (state_d == ST_FETCH);
    valid_d   = (state_d == ST_ISSUE);
    capture_c = (state_q == ST_WAIT)  && imem_rvalid_i;
    consume_c = (state_q == ST_ISSUE) && !stall_i;
  end

  // Redirect priority: jump over taken branch over sequential
  always_comb begin
    if (jump_i) begin
      next_pc_c = jump_target_i & ALIGN_MASK;
    end else if (branch_taken_i) begin
      next_pc_c = branch_target_i & ALIGN_MASK;
    end else begin
      next_pc_c = pc_q + PC_STEP;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    count_d    = count_q;
    if (capture_c) begin
      instr_d    = imem_rdata_i;
      pc_out_d   = pc_q;
      pc_plus4_d = pc_q + PC_STEP;
    end
    if (consume_c) begin
      pc_d    = next_pc_c;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= PC_RESET;
      pc_out_q   <= '0;
      pc_plus4_q <= PC_STEP;
      instr_q    <= '0;
      count_q    <= '0;
    end else begin
      req_q      <= req_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[31:26];
  assign pc_out_o      = pc_out_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign issue_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (expected PC sequence and issue count) with a latency-programmable imem.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_out_o;
  logic [31:0] pc_plus4_o;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] issue_count_o;

  int          checks   = 0;
  int          failures = 0;

  // memory / reference model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] words [4];
  bit          pend;
  logic [31:0] pend_addr;
  int          wait_cnt;
  int          lat;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .opcode_o        (opcode_o),
    .pc_out_o        (pc_out_o),
    .pc_plus4_o      (pc_plus4_o),
    .stall_i         (stall_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .issue_count_o   (issue_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Where the decoder wants to go next after consuming the instruction at pc
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j,
                                             input logic [31:0] jt, input logic b,
                                             input logic [31:0] bt);
    if (j) return {jt[31:2], 2'b00};
    if (b) return {bt[31:2], 2'b00};
    return pc + 32'd4;
  endfunction

  // One clock: update the model from this cycle's handshake, advance, then drive imem response
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_o && imem_gnt_i && !rst_i;
    a   = imem_addr_o;
    if (imem_rvalid_i || rst_i) pend = 1'b0;
    if (instr_valid_o && !stall_i && !rst_i) begin
      m_pc    = model_next(m_pc, jump_i, jump_target_i, branch_taken_i, branch_target_i);
      m_count = m_count + 32'd1;
    end
    if (rst_i) begin
      m_pc    = RST_PC;
      m_count = 32'd0;
    end
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      wait_cnt  = lat - 1;
    end else if (pend && wait_cnt > 0) begin
      wait_cnt = wait_cnt - 1;
    end
    if (pend && wait_cnt == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr);
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    for (int i = 0; i < max && !instr_valid_o; i++) tick();
    ok = instr_valid_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
    checks++; if (pc_out_o !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=0", pc_out_o); end
    checks++; if (issue_count_o !== 32'h0) begin failures++; $display("FAIL rst_count got=%0d exp=0", issue_count_o); end
    checks++; if (pc_plus4_o !== 32'h4) begin failures++; $display("FAIL rst_pc_plus4 got=%h exp=4", pc_plus4_o); end
    rst_i = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
      failures++; $display("FAIL first_req got req=%0h addr=%h exp req=1 addr=%h", imem_req_o, imem_addr_o, RST_PC);
    end
    tick();
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      failures++; $display("FAIL wait_cycle got valid=%0h req=%0h exp 0 0", instr_valid_o, imem_req_o);
    end
    tick();
    checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL latency2 got valid=%0h exp=1", instr_valid_o); end
    checks++; if (pc_out_o !== RST_PC || instr_o !== mem_word(RST_PC)) begin
      failures++; $display("FAIL first_instr got pc=%h instr=%h exp pc=%h instr=%h", pc_out_o, instr_o, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_sequential();
    bit ok;
    jump_i = 1'b1; jump_target_i = 32'h0;
    tick();
    jump_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      failures++; $display("FAIL seq_start got req=%0h addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, ok);
      checks++; if (!ok) begin failures++; $display("FAIL seq_timeout_%0d got valid=0 exp=1", k); end
      checks++; if (pc_out_o !== 32'(4 * k) || instr_o !== words[k]) begin
        failures++; $display("FAIL seq_word_%0d got pc=%h instr=%h exp pc=%h instr=%h", k, pc_out_o, instr_o, 32'(4 * k), words[k]);
      end
      checks++; if (opcode_o !== words[k][31:26] || pc_plus4_o !== 32'(4 * k + 4)) begin
        failures++; $display("FAIL seq_op_%0d got op=%b pc4=%h", k, opcode_o, pc_plus4_o);
      end
      checks++; if (issue_count_o !== 32'(1 + k)) begin
        failures++; $display("FAIL seq_count_%0d got=%0d exp=%0d", k, issue_count_o, 1 + k);
      end
      if (k == 0) begin
        checks++; if (opcode_o !== 6'b100011) begin failures++; $display("FAIL lw_opcode got=%b exp=100011", opcode_o); end
      end
      tick();
    end
    checks++; if (imem_addr_o !== 32'h10 || issue_count_o !== 32'd5) begin
      failures++; $display("FAIL seq_end got addr=%h count=%0d exp addr=10 count=5", imem_addr_o, issue_count_o);
    end
  endtask

  task automatic test_gnt_hold();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || instr_valid_o !== 1'b0) begin
        failures++; $display("FAIL gnt_hold_%0d got req=%0h addr=%h valid=%0h exp 1 10 0", i, imem_req_o, imem_addr_o, instr_valid_o);
      end
    end
    imem_gnt_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      failures++; $display("FAIL gnt_accept got req=%0h valid=%0h exp 0 0", imem_req_o, instr_valid_o);
    end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || pc_out_o !== 32'h10 || instr_o !== mem_word(32'h10)) begin
      failures++; $display("FAIL gnt_capture got valid=%0h pc=%h instr=%h exp 1 10 %h", instr_valid_o, pc_out_o, instr_o, mem_word(32'h10));
    end
  endtask

  task automatic test_stall_redirect();
    bit ok;
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid_o !== 1'b1 || pc_out_o !== 32'h10 || instr_o !== mem_word(32'h10)
                    || issue_count_o !== 32'd5 || imem_req_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold_%0d got valid=%0h pc=%h count=%0d req=%0h", i, instr_valid_o, pc_out_o, issue_count_o, imem_req_o);
      end
    end
    stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h43;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || issue_count_o !== 32'd6) begin
      failures++; $display("FAIL branch_redirect got req=%0h addr=%h count=%0d exp 1 40 6", imem_req_o, imem_addr_o, issue_count_o);
    end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out_o !== 32'h40 || issue_count_o !== 32'd6) begin
      failures++; $display("FAIL branch_issue got valid=%0h pc=%h count=%0d exp 1 40 6", instr_valid_o, pc_out_o, issue_count_o);
    end
  endtask

  task automatic test_priority_wrap();
    bit ok;
    jump_i = 1'b1; branch_taken_i = 1'b1; jump_target_i = 32'h200; branch_target_i = 32'h80;
    tick();
    jump_i = 1'b0; branch_taken_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h200) begin failures++; $display("FAIL jump_priority got addr=%h exp=200", imem_addr_o); end
    wait_valid(10, ok);
    jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFE;
    tick();
    jump_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jump_mask got addr=%h exp=fffffffc", imem_addr_o); end
    wait_valid(10, ok);
    checks++; if (!ok || pc_out_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      failures++; $display("FAIL top_issue got pc=%h pc4=%h exp fffffffc 0", pc_out_o, pc_plus4_o);
    end
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || issue_count_o !== 32'd9) begin
      failures++; $display("FAIL pc_wrap got req=%0h addr=%h count=%0d exp 1 0 9", imem_req_o, imem_addr_o, issue_count_o);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    lat = 2;
    tick();
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      failures++; $display("FAIL in_wait got req=%0h valid=%0h exp 0 0", imem_req_o, instr_valid_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    checks++; if (instr_valid_o !== 1'b0 || issue_count_o !== 32'd0 || instr_o !== 32'h0 || imem_req_o !== 1'b0) begin
      failures++; $display("FAIL midrst got valid=%0h count=%0d instr=%h req=%0h exp 0 0 0 0", instr_valid_o, issue_count_o, instr_o, imem_req_o);
    end
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || instr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
      failures++; $display("FAIL stray_rvalid got req=%0h addr=%h instr=%h valid=%0h", imem_req_o, imem_addr_o, instr_o, instr_valid_o);
    end
    lat = 1;
    wait_valid(10, ok);
    checks++; if (!ok || pc_out_o !== RST_PC || instr_o !== mem_word(RST_PC) || issue_count_o !== 32'd0) begin
      failures++; $display("FAIL restart got pc=%h instr=%h count=%0d exp %h %h 0", pc_out_o, instr_o, issue_count_o, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_random_stream();
    int  idle = 0;
    int  issued = 0;
    bit  hung = 1'b0;
    for (int c = 0; c < 3000 && !hung; c++) begin
      if (imem_req_o) begin
        checks++; if (imem_addr_o !== m_pc) begin
          failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr_o, m_pc);
        end
      end
      if (instr_valid_o) begin
        idle = 0;
        issued++;
        checks++; if (pc_out_o !== m_pc || instr_o !== mem_word(m_pc) || opcode_o !== mem_word(m_pc) >> 26
                      || pc_plus4_o !== m_pc + 32'd4 || issue_count_o !== m_count) begin
          failures++; $display("FAIL rnd_issue c=%0d got pc=%h instr=%h op=%b pc4=%h count=%0d exp pc=%h count=%0d",
                               c, pc_out_o, instr_o, opcode_o, pc_plus4_o, issue_count_o, m_pc, m_count);
        end
      end else begin
        idle++;
        if (idle > 60) hung = 1'b1;
      end
      rst_i           = ($urandom_range(0, 499) == 0);
      imem_gnt_i      = ($urandom_range(0, 3) != 0);
      stall_i         = ($urandom_range(0, 3) == 0);
      jump_i          = ($urandom_range(0, 7) == 0);
      branch_taken_i  = ($urandom_range(0, 5) == 0);
      jump_target_i   = $urandom;
      branch_target_i = $urandom;
      lat             = $urandom_range(1, 3);
      tick();
    end
    rst_i = 1'b0;
    checks++; if (hung) begin failures++; $display("FAIL rnd_progress got idle=%0d exp<=60", idle); end
    checks++; if (issued < 200) begin failures++; $display("FAIL rnd_volume got=%0d exp>=200", issued); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    words[0] = 32'h8C01_0004;
    words[1] = 32'hAC02_0008;
    words[2] = 32'h0022_1820;
    words[3] = 32'h1022_FFFC;
    for (int k = 0; k < 4; k++) mem[32'(4 * k)] = words[k];
    rst_i = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
    jump_target_i = 32'h0; branch_target_i = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; wait_cnt = 0; lat = 1;
    m_pc = RST_PC; m_count = 32'd0;

    test_reset();
    test_sequential();
    test_gnt_hold();
    test_stall_redirect();
    test_priority_wrap();
    test_reset_in_wait();
    test_random_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
